shared_data_memory: RTL and testbench
=====================================

Name: shared_data_memory

Overview:
- Responder side of the core data-memory interface: a single-port data RAM shared by NUM_CORES matrix-multiplication cores.
- Cores issue read/write requests; the block arbitrates round-robin, performs one access per cycle, and returns an ack plus read data.
- A host port with absolute priority preloads the operand matrices and reads back the results.

Parameters:
NUM_CORES, 4, number of core request ports
ADDR_WIDTH, 8, word address width; memory depth is 2**ADDR_WIDTH
DATA_WIDTH, 16, word width

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
core_req  input  NUM_CORES  per-core request; held until ack
core_we  input  NUM_CORES  per-core write enable (1 = write, 0 = read), qualified by core_req
core_addr  input  NUM_CORES*ADDR_WIDTH  per-core word address, core n at slice [n*ADDR_WIDTH +: ADDR_WIDTH]
core_wdata  input  NUM_CORES*DATA_WIDTH  per-core write data, same slicing
core_ack  output  NUM_CORES  one-cycle pulse: access completed
core_rdata  output  NUM_CORES*DATA_WIDTH  per-core read-data holding register
host_en  input  1  host access this cycle
host_we  input  1  host write enable
host_addr  input  ADDR_WIDTH  host address
host_wdata  input  DATA_WIDTH  host write data
host_rdata  output  DATA_WIDTH  host read data, registered
busy  output  1  registered; 1 while any unserved core_req is pending

Behaviour:
- Reset (synchronous, active-high):
  - core_ack=0, core_rdata=0, host_rdata=0, busy=0.
  - RR pointer last_grant=NUM_CORES-1, so core 0 has first priority.
  - RAM contents are not cleared.
  - An access presented in the reset cycle is not performed; an ack pending at reset is dropped.
- Cycle t, host_en=1:
  - Host owns the RAM.
  - Write: mem[host_addr]<=host_wdata at edge t.
  - Read: host_rdata<=mem[host_addr] at edge t, i.e. valid in cycle t+1.
  - No core is granted, last_grant is unchanged, and host_rdata holds its value otherwise.
- Cycle t, host_en=0, arbitration:
  - eligible[n] = core_req[n] & ~core_ack[n]. Masking a core acked this cycle prevents double service, because its req is still high in the ack cycle.
  - Winner w = first eligible index searching from last_grant+1 upward, wrapping modulo NUM_CORES.
  - No eligible core: no access, last_grant unchanged.
- Grant of core w at edge t:
  - last_grant<=w.
  - If we: mem[addr_w]<=wdata_w.
  - Else: core_rdata[w]<=mem[addr_w].
  - core_ack[w]=1 during cycle t+1 only; all other acks are 0.
  - core_rdata[w] is valid in that same cycle and is held until core w's next read ack. Writes do not alter core_rdata.
- Latency:
  - Uncontended request: ack one cycle after req is asserted.
  - Core n waits at most NUM_CORES grants plus any host cycles.
  - Aggregate throughput is one access per cycle; a single core gets at most one access per two cycles.
- Core protocol:
  - Hold req/we/addr/wdata stable until ack.
  - Deassert req, or present the next request, in the cycle after ack.
  - Changing addr/we/wdata while unacked is undefined.
- Ordering: accesses are serialized in grant order. A read granted in the cycle after a write to the same address returns the new data; there is no read-during-write within one cycle since only one access occurs per cycle.
- busy: registered |(core_req & ~core_ack & ~grant_onehot), computed each cycle.
- Arithmetic: the RR pointer is $clog2(NUM_CORES) bits wide and wraps modulo NUM_CORES; NUM_CORES need not be a power of two.

Test Plan:
1. Host writes mem[0x10]=0x1234, then host reads 0x10 -> host_rdata=0x1234 in the cycle after host_en.
2. Core 2 alone reads 0x10 -> core_ack[2] pulses exactly one cycle after req; core_rdata slice 2=0x1234; other slices stay 0.
3. All 4 cores request reads in the same cycle after reset -> acks in order core0,1,2,3 on consecutive cycles. Re-requesting immediately -> order 0,1,2,3 again with no core served twice in a row.
4. Core 1 writes 0xBEEF to 0x20 while host_en=1 for 3 cycles -> no core_ack during host cycles; write lands afterwards; host read of 0x20 then returns 0xBEEF.
5. Core 0 writes 0xAAAA to 0x05 and core 1 reads 0x05 in the same cycle -> core 0 granted first; core 1's ack follows with core_rdata=0xAAAA.
6. reset asserted in the cycle a core 3 write to 0x30 (0x5555) is presented -> no ack, mem[0x30] unchanged, all outputs 0; the next request from core 0 is granted first.

Source files
------------

// File: rtl/shared_data_memory_if.sv
`default_nettype none
// ============================================================================
//  Module   : shared_data_memory_if
//  Brief    : Core request/ack bus and host preload port of the shared data RAM.
//  Revision : 1.0 - initial release
// ============================================================================
interface shared_data_memory_if #(
    parameter int NUM_CORES  = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    logic [NUM_CORES-1:0]            core_req;
    logic [NUM_CORES-1:0]            core_we;
    logic [NUM_CORES*ADDR_WIDTH-1:0] core_addr;
    logic [NUM_CORES*DATA_WIDTH-1:0] core_wdata;
    logic [NUM_CORES-1:0]            core_ack;
    logic [NUM_CORES*DATA_WIDTH-1:0] core_rdata;
    logic                            host_en;
    logic                            host_we;
    logic [ADDR_WIDTH-1:0]           host_addr;
    logic [DATA_WIDTH-1:0]           host_wdata;
    logic [DATA_WIDTH-1:0]           host_rdata;
    logic                            busy;

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        output host_en, host_we, host_addr, host_wdata,
        input  core_ack, core_rdata, host_rdata, busy
    );

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        input  host_en, host_we, host_addr, host_wdata,
        output core_ack, core_rdata, host_rdata, busy
    );
endinterface
`default_nettype wire

// File: rtl/shared_data_memory.sv
`default_nettype none
// ============================================================================
//  Module   : shared_data_memory
//  Brief    : Single-port data RAM shared by NUM_CORES cores, round-robin
//             arbitration, one access per cycle, host port has priority.
//  Revision : 1.0 - initial release
// ============================================================================
module shared_data_memory #(
    parameter int NUM_CORES  = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  wire logic             clock,
    input  wire logic             reset,
    shared_data_memory_if.slave   bus
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;
    localparam int c_PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic [DATA_WIDTH-1:0]           r_mem [c_DEPTH];
    logic [c_PTR_W-1:0]              r_last_grant;
    logic [NUM_CORES-1:0]            r_core_ack;
    logic [NUM_CORES*DATA_WIDTH-1:0] r_core_rdata;
    logic [DATA_WIDTH-1:0]           r_host_rdata;
    logic                            r_busy;

    logic [NUM_CORES-1:0]            w_eligible;
    logic [NUM_CORES-1:0]            w_grant_onehot;
    logic [c_PTR_W-1:0]              w_winner;
    logic                            w_found;
    logic                            w_grant_valid;
    logic                            w_sel_we;
    logic [ADDR_WIDTH-1:0]           w_sel_addr;
    logic [DATA_WIDTH-1:0]           w_sel_wdata;

    // A core whose ack is visible this cycle still holds req; masking it
    // prevents serving the same request twice.
    assign w_eligible = bus.core_req & ~r_core_ack;

    always_comb begin
        int w_idx;
        w_idx    = 0;
        w_found  = 1'b0;
        w_winner = r_last_grant;
        for (int off = 1; off <= NUM_CORES; off++) begin
            w_idx = (int'(r_last_grant) + off) % NUM_CORES;
            if (!w_found && w_eligible[w_idx]) begin
                w_found  = 1'b1;
                w_winner = c_PTR_W'(w_idx);
            end
        end
    end

    assign w_grant_valid  = !bus.host_en && w_found;
    assign w_grant_onehot = w_grant_valid ? (NUM_CORES'(1) << w_winner) : '0;

    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int n = 0; n < NUM_CORES; n++) begin
            if (w_winner == c_PTR_W'(n)) begin
                w_sel_we    = bus.core_we[n];
                w_sel_addr  = bus.core_addr[n*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_wdata = bus.core_wdata[n*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // RAM contents survive reset; only the access presented during reset is dropped.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (bus.host_en) begin
                if (bus.host_we) begin
                    r_mem[bus.host_addr] <= bus.host_wdata;
                end
            end else if (w_grant_valid && w_sel_we) begin
                r_mem[w_sel_addr] <= w_sel_wdata;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_grant <= c_PTR_W'(NUM_CORES - 1);
            r_core_ack   <= '0;
            r_core_rdata <= '0;
            r_host_rdata <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_core_ack <= w_grant_onehot;
            r_busy     <= |(bus.core_req & ~r_core_ack & ~w_grant_onehot);
            if (bus.host_en && !bus.host_we) begin
                r_host_rdata <= r_mem[bus.host_addr];
            end
            if (w_grant_valid) begin
                r_last_grant <= w_winner;
                for (int n = 0; n < NUM_CORES; n++) begin
                    if (!w_sel_we && (w_winner == c_PTR_W'(n))) begin
                        r_core_rdata[n*DATA_WIDTH +: DATA_WIDTH] <= r_mem[w_sel_addr];
                    end
                end
            end
        end
    end

    assign bus.core_ack   = r_core_ack;
    assign bus.core_rdata = r_core_rdata;
    assign bus.host_rdata = r_host_rdata;
    assign bus.busy       = r_busy;

    a_ack_onehot : assert property (@(posedge clock) disable iff (reset) $onehot0(r_core_ack));

endmodule
`default_nettype wire

// File: tb/tb_shared_data_memory.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shared_data_memory
//  Brief    : Directed vector bench for the shared data RAM arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shared_data_memory;

    typedef struct {
        logic        rst;
        logic        hen;
        logic        hwe;
        logic [7:0]  haddr;
        logic [15:0] hwd;
        logic [3:0]  req;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [3:0]  eack;
        logic        ebusy;
        logic [15:0] ehrd;
        logic [63:0] ecrd;
    } vec_t;

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;
    vec_t vecs[$];

    shared_data_memory_if #(.NUM_CORES(4), .ADDR_WIDTH(8), .DATA_WIDTH(16)) bus ();

    shared_data_memory #(.NUM_CORES(4), .ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] pa(input logic [7:0] a3, a2, a1, a0);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [63:0] pd(input logic [15:0] d3, d2, d1, d0);
        return {d3, d2, d1, d0};
    endfunction

    task automatic add(input logic r, hen, hwe, input logic [7:0] haddr,
                       input logic [15:0] hwd, input logic [3:0] req, we,
                       input logic [31:0] addr, input logic [63:0] wdata,
                       input logic [3:0] eack, input logic ebusy,
                       input logic [15:0] ehrd, input logic [63:0] ecrd);
        vec_t v;
        v.rst = r; v.hen = hen; v.hwe = hwe; v.haddr = haddr; v.hwd = hwd;
        v.req = req; v.we = we; v.addr = addr; v.wdata = wdata;
        v.eack = eack; v.ebusy = ebusy; v.ehrd = ehrd; v.ecrd = ecrd;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        rst            = v.rst;
        bus.host_en    = v.hen;
        bus.host_we    = v.hwe;
        bus.host_addr  = v.haddr;
        bus.host_wdata = v.hwd;
        bus.core_req   = v.req;
        bus.core_we    = v.we;
        bus.core_addr  = v.addr;
        bus.core_wdata = v.wdata;
    endtask

    initial begin
        logic [63:0] c1, c5, c27, call;
        logic [31:0] a10, a5, a20, a30r, a30b;
        logic [63:0] w5, w20, w30;
        int          waited;
        vec_t        v;

        n_total = 0;
        n_pass  = 0;
        call = {4{16'h1234}};
        c1   = pd(16'h0, 16'h1234, 16'h0, 16'h0);
        c5   = pd(16'h1234, 16'h1234, 16'hAAAA, 16'h1234);
        c27  = pd(16'h0, 16'h0, 16'h0, 16'h0F0F);
        a10  = pa(8'h10, 8'h10, 8'h10, 8'h10);
        a5   = pa(8'h00, 8'h00, 8'h05, 8'h05);
        a20  = pa(8'h00, 8'h00, 8'h20, 8'h00);
        a30r = pa(8'h30, 8'h00, 8'h00, 8'h00);
        a30b = pa(8'h30, 8'h00, 8'h00, 8'h30);
        w5   = pd(16'h0, 16'h0, 16'h0, 16'hAAAA);
        w20  = pd(16'h0, 16'h0, 16'hBEEF, 16'h0);
        w30  = pd(16'h5555, 16'h0, 16'h0, 16'h0);

        //   rst hen hwe haddr  hwd       req      we       addr  wdata  eack     busy ehrd       ecrd
        add(1, 0, 0, 8'h00, 16'h0000, 4'b0000, 4'b0000, 0,    0,     4'b0000, 0, 16'h0000, 0);
        add(0, 1, 1, 8'h10, 16'h1234, 4'b0000, 4'b0000, 0,    0,     4'b0000, 0, 16'h0000, 0);
        add(0, 1, 0, 8'h10, 16'h0000, 4'b0000, 4'b0000, 0,    0,     4'b0000, 0, 16'h1234, 0);
        add(0, 0, 0, 8'h00, 16'h0000, 4'b0000, 4'b0000, 0,    0,     4'b0000, 0, 16'h1234, 0);
        add(0, 0, 0, 8'h00, 16'h0000, 4'b0100, 4'b0000, a10,  0,     4'b0100, 0, 16'h1234, c1);
        add(0, 0, 0, 8'h00, 16'h0000, 4'b0100, 4'b0000, a10,  0,     4'b0000, 0, 16'h1234, c1);
        add(1, 0, 0, 8'h00, 16'h0000, 4'b0000, 4'b0000, 0,    0,     4'b0000, 0, 16'h0000, 0);
        add(0, 0, 0, 8'h00, 16'h0000, 4'b1111, 4'b0000, a10,  0,     4'b0001, 1, 16'h0000, pd(0, 0, 0, 16'h1234));
        add(0, 0, 0, 8'h00, 16'h0000, 4'b1111, 4'b0000, a10,  0,     4'b0010, 1, 16'h0000, pd(0, 0, 16'h1234, 16'h1234));
        add(0, 0, 0, 8'h00, 16'h0000, 4'b1111, 4'b0000, a10,  0,     4'b0100, 1, 16'h0000, pd(0, 16'h1234, 16'h1234, 16'h1234));
        add(0, 0, 0, 8'h00, 16'h0000, 4'b1111, 4'b0000, a10,  0,     4'b1000, 1, 16'h0000, call);
        add(0, 0, 0, 8'h00, 16'h0000, 4'b1111, 4'b0000, a10,  0,     4'b0001, 1, 16'h0000, call);
        add(0, 0, 0, 8'h00, 16'h0000, 4'b1111, 4'b0000, a10,  0,     4'b0010, 1, 16'h0000, call);
        add(0, 0, 0, 8'h00, 16'h0000, 4'b1110, 4'b0000, a10,  0,     4'b0100, 1, 16'h0000, call);
        add(0, 0, 0, 8'h00, 16'h0000, 4'b1100, 4'b0000, a10,  0,     4'b1000, 0, 16'h0000, call);
        add(0, 0, 0, 8'h00, 16'h0000, 4'b1000, 4'b0000, a10,  0,     4'b0000, 0, 16'h0000, call);
        add(0, 0, 0, 8'h00, 16'h0000, 4'b0011, 4'b0001, a5,   w5,    4'b0001, 1, 16'h0000, call);
        add(0, 0, 0, 8'h00, 16'h0000, 4'b0011, 4'b0001, a5,   w5,    4'b0010, 0, 16'h0000, c5);
        add(0, 0, 0, 8'h00, 16'h0000, 4'b0010, 4'b0000, a5,   w5,    4'b0000, 0, 16'h0000, c5);
        add(0, 1, 0, 8'h05, 16'h0000, 4'b0010, 4'b0010, a20,  w20,   4'b0000, 1, 16'hAAAA, c5);
        add(0, 1, 0, 8'h10, 16'h0000, 4'b0010, 4'b0010, a20,  w20,   4'b0000, 1, 16'h1234, c5);
        add(0, 1, 0, 8'h05, 16'h0000, 4'b0010, 4'b0010, a20,  w20,   4'b0000, 1, 16'hAAAA, c5);
        add(0, 0, 0, 8'h00, 16'h0000, 4'b0010, 4'b0010, a20,  w20,   4'b0010, 0, 16'hAAAA, c5);
        add(0, 0, 0, 8'h00, 16'h0000, 4'b0010, 4'b0010, a20,  w20,   4'b0000, 0, 16'hAAAA, c5);
        add(0, 1, 0, 8'h20, 16'h0000, 4'b0000, 4'b0000, 0,    0,     4'b0000, 0, 16'hBEEF, c5);
        add(0, 1, 1, 8'h30, 16'h0F0F, 4'b0000, 4'b0000, 0,    0,     4'b0000, 0, 16'hBEEF, c5);
        add(1, 0, 0, 8'h00, 16'h0000, 4'b1000, 4'b1000, a30r, w30,   4'b0000, 0, 16'h0000, 0);
        add(0, 0, 0, 8'h00, 16'h0000, 4'b1001, 4'b1000, a30b, w30,   4'b0001, 1, 16'h0000, c27);
        add(0, 0, 0, 8'h00, 16'h0000, 4'b1001, 4'b1000, a30b, w30,   4'b1000, 0, 16'h0000, c27);
        add(0, 0, 0, 8'h00, 16'h0000, 4'b1000, 4'b1000, a30b, w30,   4'b0000, 0, 16'h0000, c27);
        add(0, 1, 0, 8'h30, 16'h0000, 4'b0000, 4'b0000, 0,    0,     4'b0000, 0, 16'h5555, c27);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d core_ack", i),   {60'h0, bus.core_ack}, {60'h0, vecs[i].eack});
            chk($sformatf("v%0d busy", i),       {63'h0, bus.busy},     {63'h0, vecs[i].ebusy});
            chk($sformatf("v%0d host_rdata", i), {48'h0, bus.host_rdata}, {48'h0, vecs[i].ehrd});
            chk($sformatf("v%0d core_rdata", i), bus.core_rdata,        vecs[i].ecrd);
        end

        // Core 1 reads back what it wrote earlier; ack must follow in one cycle.
        v = vecs[0];
        v.rst  = 1'b0;
        v.req  = 4'b0010;
        v.addr = pa(8'h00, 8'h00, 8'h20, 8'h00);
        @(negedge clk);
        drive(v);
        waited = 0;
        do begin
            @(posedge clk);
            #1;
            waited++;
        end while (!bus.core_ack[1] && waited < 4);
        chk("seq ack latency", 64'(waited), 64'd1);
        chk("seq core1 rdata", bus.core_rdata, pd(16'h0, 16'h0, 16'hBEEF, 16'h0F0F));
        // Req still held in the ack cycle must not be served again.
        @(posedge clk);
        #1;
        chk("seq no double ack", {60'h0, bus.core_ack}, 64'h0);
        @(negedge clk);
        bus.core_req = 4'b0000;
        @(posedge clk);
        #1;
        chk("seq idle busy", {63'h0, bus.busy}, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
